// File: rtl/regfile_arb_pkg.sv
// Shared register-file geometry and arbiter FSM state type for regfile_port_arbiter.
// Build option: REGFILE_ARB_LOCK_EN (requester lock) is consumed by the top, not here.
package regfile_arb_pkg;

    localparam int REG_AW = 3;
    localparam int REG_DW = 8;
    localparam int NREGS  = 8;

    typedef enum logic {
        CLEAR,
        SERVE
    } arb_state_t;

endpackage

// File: rtl/regfile_port_arbiter_rr.sv
// Combinational round-robin picker: first valid requester strictly after ptr_i, wrapping.
// Holds no state; the pointer register belongs to the parent.
module rr_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] valid_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IW-1:0]   idx_o
);

    logic found;

    // Two passes: indices above the pointer first, then wrap to 0..ptr.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && valid_i[i] && (IW'(i) > ptr_i)) begin
                found      = 1'b1;
                grant_o[i] = 1'b1;
                idx_o      = IW'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!found && valid_i[i] && (IW'(i) <= ptr_i)) begin
                found      = 1'b1;
                grant_o[i] = 1'b1;
                idx_o      = IW'(i);
            end
        end
    end

endmodule

// File: rtl/regfile_port_arbiter.sv
// Shares the register file's read1 and write ports among NREQ requesters and clears all registers after reset or on clr_start.
// Build option: define REGFILE_ARB_LOCK_EN to add the req_lock port and exclusive ownership.
module regfile_port_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int NREQ             = 2,
    parameter int R0_WRITE_PROTECT = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ-1:0]          req_we,
    input  logic [REG_AW*NREQ-1:0]   req_addr,
    input  logic [REG_DW*NREQ-1:0]   req_wdata,
    output logic [NREQ-1:0]          req_ready,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [REG_DW-1:0]        rsp_data,
`ifdef REGFILE_ARB_LOCK_EN
    input  logic [NREQ-1:0]          req_lock,
`endif
    input  logic                     clr_start,
    output logic                     busy,
    output logic [REG_AW-1:0]        rf_reg1,
    input  logic [REG_DW-1:0]        rf_read1,
    output logic [REG_AW-1:0]        rf_regw,
    output logic [REG_DW-1:0]        rf_write,
    output logic                     rf_regwrite
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_t        state_q, state_d;
    logic [REG_AW-1:0] cnt_q, cnt_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [REG_DW-1:0] rsp_data_q, rsp_data_d;

    logic [NREQ-1:0]   arb_valid;
    logic [NREQ-1:0]   grant;
    logic [IW-1:0]     gidx;
    logic              hs;
    logic              g_we;
    logic [REG_AW-1:0] g_addr;
    logic [REG_DW-1:0] g_wdata;
    logic              wr_commit;

`ifdef REGFILE_ARB_LOCK_EN
    logic          owner_vld_q, owner_vld_d;
    logic [IW-1:0] owner_q, owner_d;

    // A live owner masks every other requester out of arbitration.
    always_comb begin
        arb_valid = req_valid;
        if (owner_vld_q && req_valid[owner_q]) begin
            arb_valid          = '0;
            arb_valid[owner_q] = 1'b1;
        end
    end

    always_comb begin
        owner_vld_d = owner_vld_q;
        owner_d     = owner_q;
        if ((state_q == CLEAR) || clr_start) begin
            owner_vld_d = 1'b0;
        end else if (hs && req_lock[gidx]) begin
            owner_vld_d = 1'b1;
            owner_d     = gidx;
        end else if (hs && owner_vld_q && (gidx == owner_q)) begin
            owner_vld_d = 1'b0;
        end else if (owner_vld_q && !req_valid[owner_q]) begin
            owner_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_vld_q <= 1'b0;
            owner_q     <= '0;
        end else begin
            owner_vld_q <= owner_vld_d;
            owner_q     <= owner_d;
        end
    end
`else
    assign arb_valid = req_valid;
`endif

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr (
        .valid_i (arb_valid),
        .ptr_i   (ptr_q),
        .grant_o (grant),
        .idx_o   (gidx)
    );

    always_comb begin
        g_we    = 1'b0;
        g_addr  = '0;
        g_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                g_we    = req_we[i];
                g_addr  = req_addr[i*REG_AW +: REG_AW];
                g_wdata = req_wdata[i*REG_DW +: REG_DW];
            end
        end
    end

    assign req_ready = (state_q == SERVE) ? grant : '0;
    assign hs        = (state_q == SERVE) && (|grant);
    assign wr_commit = hs && g_we && !((R0_WRITE_PROTECT != 0) && (g_addr == '0));
    assign busy      = (state_q == CLEAR);
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

    // Clear writes are gated by rst so the port stays quiet while reset is held.
    always_comb begin
        rf_reg1     = '0;
        rf_regw     = '0;
        rf_write    = '0;
        rf_regwrite = 1'b0;
        if (state_q == CLEAR) begin
            rf_regw     = cnt_q;
            rf_regwrite = rst;
        end else if (hs) begin
            if (g_we) begin
                rf_regw     = g_addr;
                rf_write    = g_wdata;
                rf_regwrite = wr_commit;
            end else begin
                rf_reg1 = g_addr;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        if (state_q == CLEAR) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == REG_AW'(NREGS - 1)) begin
                state_d = SERVE;
            end
        end else begin
            if (hs) begin
                ptr_d = gidx;
                if (!g_we) begin
                    rsp_valid_d = grant;
                    rsp_data_d  = rf_read1;
                end
            end
            // The handshake above still completes; the clear starts next cycle.
            if (clr_start) begin
                state_d = CLEAR;
                cnt_d   = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= CLEAR;
            cnt_q       <= '0;
            ptr_q       <= IW'(NREQ - 1);
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Scoreboard bench for regfile_port_arbiter with a behavioural register file and reference model.
// Define REGFILE_ARB_LOCK_EN to also exercise requester locking.
module tb_regfile_port_arbiter;

    localparam int NREQ  = 2;
    localparam int R0_WP = 1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid, req_we, req_ready, rsp_valid;
    logic [3*NREQ-1:0]    req_addr;
    logic [8*NREQ-1:0]    req_wdata;
    logic [7:0]           rsp_data;
    logic                 clr_start, busy;
    logic [2:0]           rf_reg1, rf_regw;
    logic [7:0]           rf_read1, rf_write;
    logic                 rf_regwrite;
`ifdef REGFILE_ARB_LOCK_EN
    logic [NREQ-1:0]      req_lock;
    int                   mOwner;
`endif

    typedef struct {
        int         who;
        logic [7:0] data;
    } rsp_t;

    rsp_t       sbQ[$];
    logic [7:0] refRegs [8];
    logic [7:0] rfMem [8];
    int         mPtr;
    int         nChecks = 0;
    int         nErrors = 0;

    always #5 clk = ~clk;

    regfile_port_arbiter #(
        .NREQ             (NREQ),
        .R0_WRITE_PROTECT (R0_WP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
`ifdef REGFILE_ARB_LOCK_EN
        .req_lock    (req_lock),
`endif
        .clr_start   (clr_start),
        .busy        (busy),
        .rf_reg1     (rf_reg1),
        .rf_read1    (rf_read1),
        .rf_regw     (rf_regw),
        .rf_write    (rf_write),
        .rf_regwrite (rf_regwrite)
    );

    // Register file stand-in; filled with junk while reset is held so the clear is visible.
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) rfMem[i] <= 8'($urandom);
        end else if (rf_regwrite) begin
            rfMem[rf_regw] <= rf_write;
        end
    end
    assign rf_read1 = rfMem[rf_reg1];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nErrors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: every response slot is matched against the oldest queued expectation.
    always @(posedge clk) begin
        rsp_t e;
        #1;
        if (rst && ((rsp_valid != '0) || (sbQ.size() > 0))) begin
            if (sbQ.size() == 0) begin
                checkOutput("unexpected_rsp_valid", 32'(rsp_valid), 32'd0);
            end else begin
                e = sbQ.pop_front();
                checkOutput("rsp_valid", 32'(rsp_valid), 32'(1) << e.who);
                checkOutput("rsp_data", 32'(rsp_data), 32'(e.data));
            end
        end
    end

    task automatic checkClear(input int nCycles);
        for (int k = 0; k < nCycles; k++) begin
            req_valid = NREQ'($urandom);
            req_we    = NREQ'($urandom);
            #1;
            checkOutput("clr_busy", 32'(busy), 32'd1);
            checkOutput("clr_regwrite", 32'(rf_regwrite), 32'd1);
            checkOutput("clr_regw", 32'(rf_regw), 32'(k));
            checkOutput("clr_write", 32'(rf_write), 32'd0);
            checkOutput("clr_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        req_valid = '0;
        if (nCycles == 8) begin
            for (int i = 0; i < 8; i++) refRegs[i] = 8'h00;
        end
`ifdef REGFILE_ARB_LOCK_EN
        mOwner = -1;
`endif
    endtask

    // One serve cycle: drive at negedge, check combinational outputs, advance the model at the edge.
    task automatic applyStimulus(input logic [NREQ-1:0] v, input logic [NREQ-1:0] we,
                                 input logic [3*NREQ-1:0] a, input logic [8*NREQ-1:0] d,
                                 input logic clr);
        int              g;
        logic [2:0]      ad;
        logic [7:0]      wd;
        logic [NREQ-1:0] expReady;
        logic            expWe;
        req_valid = v;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        clr_start = clr;
        #1;
        g = -1;
        for (int k = 1; k <= NREQ; k++) begin
            if (g < 0 && v[(mPtr + k) % NREQ]) g = (mPtr + k) % NREQ;
        end
`ifdef REGFILE_ARB_LOCK_EN
        if (mOwner >= 0 && v[mOwner]) g = mOwner;
`endif
        expReady = '0;
        if (g >= 0) expReady[g] = 1'b1;
        checkOutput("busy", 32'(busy), 32'd0);
        checkOutput("req_ready", 32'(req_ready), 32'(expReady));
        if (g >= 0) begin
            ad = a[3*g +: 3];
            wd = d[8*g +: 8];
            if (we[g]) begin
                expWe = !(ad == 3'd0 && R0_WP != 0);
                checkOutput("wr_regwrite", 32'(rf_regwrite), 32'(expWe));
                if (expWe) begin
                    checkOutput("wr_regw", 32'(rf_regw), 32'(ad));
                    checkOutput("wr_data", 32'(rf_write), 32'(wd));
                    refRegs[ad] = wd;
                end
            end else begin
                checkOutput("rd_reg1", 32'(rf_reg1), 32'(ad));
                checkOutput("rd_regwrite", 32'(rf_regwrite), 32'd0);
                sbQ.push_back('{who: g, data: refRegs[ad]});
            end
        end else begin
            checkOutput("idle_regwrite", 32'(rf_regwrite), 32'd0);
            checkOutput("idle_reg1", 32'(rf_reg1), 32'd0);
        end
        @(posedge clk);
        if (g >= 0) mPtr = g;
`ifdef REGFILE_ARB_LOCK_EN
        if (clr) mOwner = -1;
        else if (g >= 0 && req_lock[g]) mOwner = g;
        else if (g >= 0 && g == mOwner) mOwner = -1;
        else if (mOwner >= 0 && !v[mOwner]) mOwner = -1;
`endif
        @(negedge clk);
        clr_start = 1'b0;
        req_valid = '0;
        if (clr) checkClear(8);
    endtask

    task automatic singleOp(input int who, input logic we, input int addr, input int data, input logic clr);
        logic [NREQ-1:0]   v, w;
        logic [3*NREQ-1:0] a;
        logic [8*NREQ-1:0] d;
        v = '0;
        w = '0;
        a = '0;
        d = '0;
        v[who]        = 1'b1;
        w[who]        = we;
        a[3*who +: 3] = 3'(addr);
        d[8*who +: 8] = 8'(data);
        applyStimulus(v, w, a, d, clr);
    endtask

    initial begin
        rst       = 1'b0;
        req_valid = '1;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        clr_start = 1'b0;
        mPtr      = NREQ - 1;
`ifdef REGFILE_ARB_LOCK_EN
        req_lock  = '0;
        mOwner    = -1;
`endif
        repeat (2) @(negedge clk);
        checkOutput("rst_ready", 32'(req_ready), 32'd0);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_rsp_data", 32'(rsp_data), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd1);
        checkOutput("rst_regwrite", 32'(rf_regwrite), 32'd0);

        // Partial clear interrupted by reset, then a full clear from address 0.
        rst = 1'b1;
        checkClear(3);
        rst = 1'b0;
        #1;
        checkOutput("midclr_busy", 32'(busy), 32'd1);
        checkOutput("midclr_regwrite", 32'(rf_regwrite), 32'd0);
        mPtr = NREQ - 1;
        @(negedge clk);
        rst = 1'b1;
        checkClear(8);

        singleOp(0, 1'b1, 3, 8'h5A, 1'b0);
        singleOp(0, 1'b0, 3, 0, 1'b0);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(2'b11, 2'b00, {3'd2, 3'd1}, '0, 1'b0);
        end

        singleOp(1, 1'b1, 0, 8'hFF, 1'b0);
        singleOp(1, 1'b0, 0, 0, 1'b0);

        singleOp(0, 1'b0, 3, 0, 1'b1);
        singleOp(0, 1'b0, 3, 0, 1'b0);

`ifdef REGFILE_ARB_LOCK_EN
        singleOp(1, 1'b0, 4, 0, 1'b0);
        req_lock = 2'b01;
        for (int i = 0; i < 3; i++) applyStimulus(2'b11, 2'b00, {3'd2, 3'd1}, '0, 1'b0);
        req_lock = 2'b00;
        applyStimulus(2'b11, 2'b00, {3'd2, 3'd1}, '0, 1'b0);
        applyStimulus(2'b11, 2'b00, {3'd2, 3'd1}, '0, 1'b0);
`endif

        for (int i = 0; i < 300; i++) begin
            applyStimulus(NREQ'($urandom), NREQ'($urandom), (3*NREQ)'($urandom),
                          (8*NREQ)'($urandom), ($urandom_range(0, 39) == 0));
        end

        checkOutput("sb_empty", 32'(sbQ.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
